// File: rtl/lockstep_pkg.sv
// Shared types for the Rd1 lockstep trace producer.
// Holds the capture FSM states and the trace entry layout.
package lockstep_pkg;

    localparam int BIT_COUNT_DEF = 32;
    localparam int INDEX_W_DEF   = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } capture_state_t;

    // Default-width entry layout; the FIFO stores {index, data}
    // in this order for any BIT_COUNT/INDEX_W.
    typedef struct packed {
        logic [INDEX_W_DEF-1:0]   index;
        logic [BIT_COUNT_DEF-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/lockstep_trace_capture_if.sv
// Valid/ready trace stream from the capture block to a trace sink.
// master: out_valid/out_data/out_index out, out_ready in; slave: reverse.
interface lockstep_trace_capture_if #(
    parameter int BIT_COUNT = 32,
    parameter int INDEX_W   = 32
);
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_COUNT-1:0] out_data;
    logic [INDEX_W-1:0]   out_index;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/lockstep_trace_capture_sync_fifo.sv
// First-word-fall-through synchronous FIFO with extra-bit pointers.
// Ports: push/push_data, pop/pop_data, full, empty, count (0..DEPTH).
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is legal only when the head leaves
    // on the same edge; the write slot is then the slot being read.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/lockstep_trace_capture.sv
// Samples core Rd1 values, tags them with a sequence index, buffers
// them and streams them out. Ports: clk, reset, capture_en,
// sample_valid, sample_data, halt, trace (master stream),
// fifo_count, overflow, drop_count, done.
module lockstep_trace_capture
    import lockstep_pkg::*;
#(
    parameter int BIT_COUNT = 32,
    parameter int DEPTH     = 16,
    parameter int INDEX_W   = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      capture_en,
    input  logic                      sample_valid,
    input  logic [BIT_COUNT-1:0]      sample_data,
    input  logic                      halt,
    lockstep_trace_capture_if.master  trace,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow,
    output logic [INDEX_W-1:0]        drop_count,
    output logic                      done
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INDEX_W + BIT_COUNT;

    capture_state_t     state;
    capture_state_t     state_next;
    logic               offer;
    logic               push;
    logic               pop;
    logic               drop;
    logic               full;
    logic               empty;
    logic [INDEX_W-1:0] seq_cnt;
    logic [EW-1:0]      head;

    assign pop  = trace.out_valid & trace.out_ready;
    assign push = offer & (~full | pop);
    assign drop = offer & ~push;

    assign trace.out_valid = ~empty;
    assign trace.out_index = head[EW-1:BIT_COUNT];
    assign trace.out_data  = head[BIT_COUNT-1:0];

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({seq_cnt, sample_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FLUSH looks ahead so done rises on the same edge as the last pop.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (halt) begin
                    state_next = DONE;
                end else if (capture_en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (empty || (fifo_count == CW'(1) && pop)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        offer = (state == RUN) & sample_valid;
        done  = (state == DONE);
    end

    // Dropped offers still take an index so the sink sees the gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_cnt    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (offer) begin
                seq_cnt <= seq_cnt + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end
endmodule
